demux_1x4_32bit_buf: RTL and testbench

- Write-side counterpart of the 4-to-1 operand selector.
- Takes one 32-bit producer stream and steers each word to one of four destination channels chosen by a 2-bit select.
- Each channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer never loses data.
- Used where a single result bus fans out to four sinks, e.g. register-window write ports or per-unit operand latches.

---
 rtl/demux_1x4_32bit_buf_if.sv | 28 ++
 rtl/demux_1x4_32bit_buf.sv | 59 +++++
 tb/tb_demux_1x4_32bit_buf.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1x4_32bit_buf_if.sv
// rtl/demux_1x4_32bit_buf_if.sv - producer stream plus four buffered channel outputs of the 1x4 demux
interface demux_1x4_32bit_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] I;
    logic [1:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic [3:0]       y_valid;
    logic [3:0]       y_ready;
    logic [CNT_W-1:0] xfer_count;

    // Producer and consumers live on the master side, the demux on the slave side.
    modport master (
        output I, s, in_valid, y_ready,
        input  in_ready, Y0, Y1, Y2, Y3, y_valid, xfer_count
    );

    modport slave (
        input  I, s, in_valid, y_ready,
        output in_ready, Y0, Y1, Y2, Y3, y_valid, xfer_count
    );
endinterface

// File: rtl/demux_1x4_32bit_buf.sv
// rtl/demux_1x4_32bit_buf.sv - steers one word stream into four one-entry holding registers
module demux_1x4_32bit_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_1x4_32bit_buf_if.slave  bus
);

    logic [WIDTH-1:0] y_q [4];
    logic [3:0]       v_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_c;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;

    // Selected channel can take a word if empty or being emptied this cycle.
    always_comb begin
        ready_c = ~v_q[bus.s] | bus.y_ready[bus.s];
        accept  = bus.in_valid & ready_c;
        load    = 4'b0000;
        if (accept) begin
            load[bus.s] = 1'b1;
        end
        drain = v_q & bus.y_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
            v_q   <= 4'b0000;
            cnt_q <= '0;
        end else begin
            // A load wins over a drain so the channel keeps streaming at full rate.
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    y_q[i] <= bus.I;
                    v_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    v_q[i] <= 1'b0;
                end
            end
            cnt_q <= cnt_q + CNT_W'(accept);
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.Y0         = y_q[0];
    assign bus.Y1         = y_q[1];
    assign bus.Y2         = y_q[2];
    assign bus.Y3         = y_q[3];
    assign bus.y_valid    = v_q;
    assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_demux_1x4_32bit_buf.sv
// tb/tb_demux_1x4_32bit_buf.sv - randomized self-checking bench for demux_1x4_32bit_buf
module tb_demux_1x4_32bit_buf;

    logic clk;
    logic reset;

    demux_1x4_32bit_buf_if #(.WIDTH(32), .CNT_W(8)) bus ();

    demux_1x4_32bit_buf #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Reference model: contents and occupancy of each channel, and the word count.
    logic [31:0] md [4];
    logic [3:0]  mv;
    int          mcnt;
    logic        exp_ready;
    logic        obs_ready;

    function automatic logic [31:0] get_y(input int i);
        case (i)
            0:       return bus.Y0;
            1:       return bus.Y1;
            2:       return bus.Y2;
            default: return bus.Y3;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic [31:0] d, input logic [1:0] sel,
                         input logic v, input logic [3:0] r);
        logic acc;
        @(negedge clk);
        reset        = rst;
        bus.I        = d;
        bus.s        = sel;
        bus.in_valid = v;
        bus.y_ready  = r;
        #1;
        obs_ready = bus.in_ready;
        exp_ready = !mv[sel] || r[sel];
        acc       = v && exp_ready && !rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) md[i] = 32'h0;
            mv   = 4'b0000;
            mcnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && sel == 2'(i)) begin
                    md[i] = d;
                    mv[i] = 1'b1;
                end else if (r[i]) begin
                    mv[i] = 1'b0;
                end
            end
            if (acc) mcnt = (mcnt + 1) % 256;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000);
        drive(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000);
        n_cmp++;
        if (bus.y_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=%b", bus.y_valid, 4'b0000);
        end
        n_cmp++;
        if (bus.xfer_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.xfer_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (get_y(i) !== 32'h0) begin
                n_fail++; $display("FAIL reset_y%0d got=%h exp=0", i, get_y(i));
            end
        end
    endtask

    task automatic test_single_word();
        drive(1'b0, 32'hDEADBEEF, 2'b10, 1'b1, 4'b0000);
        n_cmp++;
        if (bus.Y2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_y2 got=%h exp=deadbeef", bus.Y2);
        end
        n_cmp++;
        if (bus.y_valid !== 4'b0100) begin
            n_fail++; $display("FAIL single_valid got=%b exp=0100", bus.y_valid);
        end
        n_cmp++;
        if (bus.xfer_count !== 8'd1) begin
            n_fail++; $display("FAIL single_count got=%0d exp=1", bus.xfer_count);
        end
        n_cmp++;
        if ({bus.Y0, bus.Y1, bus.Y3} !== 96'h0) begin
            n_fail++; $display("FAIL single_others got=%h/%h/%h exp=0", bus.Y0, bus.Y1, bus.Y3);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h12345678, 2'b10, 1'b1, 4'b0000);
            n_cmp++;
            if (obs_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", k, obs_ready);
            end
            n_cmp++;
            if (bus.Y2 !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL stall_y2 cyc=%0d got=%h exp=deadbeef", k, bus.Y2);
            end
        end
        drive(1'b0, 32'h12345678, 2'b10, 1'b1, 4'b0100);
        n_cmp++;
        if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready got=%b exp=1", obs_ready);
        end
        n_cmp++;
        if (bus.Y2 !== 32'h12345678 || bus.y_valid[2] !== 1'b1) begin
            n_fail++; $display("FAIL release_y2 got=%h v=%b exp=12345678 v=1", bus.Y2, bus.y_valid[2]);
        end
        n_cmp++;
        if (bus.xfer_count !== 8'd2) begin
            n_fail++; $display("FAIL release_count got=%0d exp=2", bus.xfer_count);
        end
    endtask

    task automatic test_streaming();
        int start;
        start = mcnt;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'(k + 1), 2'(k % 4), 1'b1, 4'b1111);
            n_cmp++;
            if (obs_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready word=%0d got=%b exp=1", k + 1, obs_ready);
            end
            n_cmp++;
            if (get_y(k % 4) !== 32'(k + 1) || bus.y_valid !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL stream_word word=%0d got=%h v=%b exp=%h v=%b",
                                   k + 1, get_y(k % 4), bus.y_valid, k + 1, 4'(1 << (k % 4)));
            end
        end
        n_cmp++;
        if (int'(bus.xfer_count) !== (start + 8) % 256) begin
            n_fail++; $display("FAIL stream_count got=%0d exp=%0d", bus.xfer_count, (start + 8) % 256);
        end
        drive(1'b0, 32'h0, 2'd0, 1'b0, 4'b1111);
    endtask

    task automatic test_parallel_drain();
        for (int k = 0; k < 4; k++) drive(1'b0, 32'hA0 + 32'(k), 2'(k), 1'b1, 4'b0000);
        n_cmp++;
        if (bus.y_valid !== 4'b1111) begin
            n_fail++; $display("FAIL fill_valid got=%b exp=1111", bus.y_valid);
        end
        drive(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b0, 4'b1111);
        n_cmp++;
        if (bus.y_valid !== 4'b0000) begin
            n_fail++; $display("FAIL drain_valid got=%b exp=0000", bus.y_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (get_y(i) !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL drain_keep_y%0d got=%h exp=%h", i, get_y(i), 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000);
        drive(1'b0, 32'h11, 2'd2, 1'b1, 4'b0000);
        drive(1'b0, 32'h22, 2'd2, 1'b1, 4'b0100);
        drive(1'b0, 32'h33, 2'd0, 1'b1, 4'b0100);
        drive(1'b0, 32'h44, 2'd1, 1'b1, 4'b0000);
        drive(1'b0, 32'h55, 2'd3, 1'b1, 4'b0000);
        n_cmp++;
        if (bus.y_valid !== 4'b1011 || bus.xfer_count !== 8'd5) begin
            n_fail++; $display("FAIL premid_state got=%b/%0d exp=1011/5", bus.y_valid, bus.xfer_count);
        end
        drive(1'b1, 32'h66, 2'd2, 1'b1, 4'b0000);
        n_cmp++;
        if (bus.y_valid !== 4'b0000 || bus.xfer_count !== 8'd0) begin
            n_fail++; $display("FAIL midrst_state got=%b/%0d exp=0000/0", bus.y_valid, bus.xfer_count);
        end
        n_cmp++;
        if ({bus.Y0, bus.Y1, bus.Y2, bus.Y3} !== 128'h0) begin
            n_fail++; $display("FAIL midrst_data got=%h/%h/%h/%h exp=0", bus.Y0, bus.Y1, bus.Y2, bus.Y3);
        end
        drive(1'b0, 32'h0, 2'd2, 1'b0, 4'b0000);
        n_cmp++;
        if (bus.y_valid[2] !== 1'b0 || bus.Y2 !== 32'h0) begin
            n_fail++; $display("FAIL midrst_pending got=%b/%h exp=0/0", bus.y_valid[2], bus.Y2);
        end
    endtask

    task automatic test_counter_wrap();
        logic [1:0]  sel;
        logic [31:0] d;
        drive(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000);
        for (int k = 0; k < 257; k++) begin
            sel = 2'($urandom_range(0, 3));
            d   = $urandom;
            drive(1'b0, d, sel, 1'b1, 4'b1111);
            if (get_y(int'(sel)) !== d) begin
                n_cmp++; n_fail++;
                $display("FAIL wrap_data k=%0d got=%h exp=%h", k, get_y(int'(sel)), d);
            end
            if (k == 255) begin
                n_cmp++;
                if (bus.xfer_count !== 8'd0) begin
                    n_fail++; $display("FAIL wrap_zero got=%0d exp=0", bus.xfer_count);
                end
            end
        end
        n_cmp++;
        if (bus.xfer_count !== 8'd1) begin
            n_fail++; $display("FAIL wrap_one got=%0d exp=1", bus.xfer_count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 99) == 0), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, obs_ready, exp_ready);
            end
            n_cmp++;
            if (bus.y_valid !== mv || int'(bus.xfer_count) !== mcnt) begin
                n_fail++; $display("FAIL rand_state k=%0d got=%b/%0d exp=%b/%0d",
                                   k, bus.y_valid, bus.xfer_count, mv, mcnt);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (get_y(i) !== md[i]) begin
                    n_fail++; $display("FAIL rand_y%0d k=%0d got=%h exp=%h", i, k, get_y(i), md[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4; i++) md[i] = 32'h0;
        mv           = 4'b0000;
        mcnt         = 0;
        reset        = 1'b1;
        bus.I        = 32'h0;
        bus.s        = 2'd0;
        bus.in_valid = 1'b0;
        bus.y_ready  = 4'b0000;

        test_reset();
        test_single_word();
        test_backpressure();
        test_streaming();
        test_parallel_drain();
        test_reset_mid();
        test_counter_wrap();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
